// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if -- bundle of the instruction-fetch stage's bus signals.
//
// Handshake semantics:
//   * IMemReq/IMemAddr: one-word read request. IMemData returns exactly one
//     cycle after the cycle in which IMemReq=1. There is no back-pressure.
//   * InstrValid/InstrReady: strict valid/ready. A transfer happens in every
//     cycle where InstrValid & InstrReady. While InstrValid=1 and
//     InstrReady=0, Instr/Op/PCOut are held stable. InstrValid never depends
//     on InstrReady.
//   * Redirect/RedirectPC: single-cycle pulse that restarts fetch.
//
// Modports:
//   slave  - the fetch unit (drives memory request and decoder-side outputs)
//   master - the environment (memory, decoder, branch unit)
// ---------------------------------------------------------------------------
interface instr_fetch_if;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic [31:0] IMemData;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        InstrValid;
   logic        InstrReady;
   logic [31:0] Instr;
   logic [5:0]  Op;
   logic [31:0] PCOut;
   logic        IllegalOp;

   modport slave (
      output IMemReq, IMemAddr, InstrValid, Instr, Op, PCOut, IllegalOp,
      input  IMemData, Redirect, RedirectPC, InstrReady
   );

   modport master (
      input  IMemReq, IMemAddr, InstrValid, Instr, Op, PCOut, IllegalOp,
      output IMemData, Redirect, RedirectPC, InstrReady
   );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- instruction fetch stage with a 2-entry instruction buffer.
//
// Holds a fetch PC, a 2-entry FIFO of {instruction, PC}, an in-flight flag for
// the single outstanding memory read, and a discard flag. Requests are issued
// only when the buffer is guaranteed to have room for the response, so the
// FIFO can never overflow.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   fetch    - instr_fetch_if.slave: memory request/response, redirect,
//              and the decoder-side valid/ready instruction stream
// Parameter:
//   RESET_PC - fetch address after reset (low two bits ignored)
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   instr_fetch_if.slave  fetch
);

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   logic [31:0] r_pc;
   logic [31:0] r_req_pc;
   logic        r_inflight;
   logic        r_discard;
   logic [31:0] r_fifo_instr [2];
   logic [31:0] r_fifo_pc    [2];
   logic        r_rd_ptr;
   logic        r_wr_ptr;
   logic [1:0]  r_count;

   logic        w_valid;
   logic        w_pop;
   logic        w_req;
   logic        w_wr;
   logic        w_legal;
   logic [2:0]  w_pending;
   logic [31:0] w_head_instr;
   logic [31:0] w_head_pc;

   assign w_valid      = (r_count != 2'd0);
   assign w_pop        = w_valid & fetch.InstrReady;
   assign w_head_instr = r_fifo_instr[r_rd_ptr];
   assign w_head_pc    = r_fifo_pc[r_rd_ptr];

   // Entries that will be occupied once everything outstanding lands. A pop
   // implies occupancy >= 1, so this never underflows.
   assign w_pending = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

   // rst_n gates the request combinationally so it drops the moment reset
   // asserts, not at the next edge.
   assign w_req = rst_n & ~fetch.Redirect & (w_pending < 3'd2);

   // A response landing in a redirect cycle, or in the cycle after one,
   // belongs to the abandoned instruction stream.
   assign w_wr = r_inflight & ~r_discard & ~fetch.Redirect;

   always_comb begin
      w_legal = 1'b0;
      case (w_head_instr[31:26])
         6'd20, 6'd25, 6'd26, 6'd39, 6'd40, 6'd41, 6'd42: w_legal = 1'b1;
         default:                                          w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc            <= RESET_PC_ALIGNED;
         r_req_pc        <= 32'h0;
         r_inflight      <= 1'b0;
         r_discard       <= 1'b0;
         r_fifo_instr[0] <= 32'h0;
         r_fifo_instr[1] <= 32'h0;
         r_fifo_pc[0]    <= 32'h0;
         r_fifo_pc[1]    <= 32'h0;
         r_rd_ptr        <= 1'b0;
         r_wr_ptr        <= 1'b0;
         r_count         <= 2'd0;
      end else begin
         r_inflight <= w_req;
         r_discard  <= fetch.Redirect;
         if (w_req) begin
            r_req_pc <= r_pc;
         end
         if (fetch.Redirect) begin
            r_pc     <= {fetch.RedirectPC[31:2], 2'b00};
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
         end else begin
            if (w_req) begin
               r_pc <= r_pc + 32'd4;  // natural wrap FFFF_FFFC -> 0
            end
            if (w_wr) begin
               r_fifo_instr[r_wr_ptr] <= fetch.IMemData;
               r_fifo_pc[r_wr_ptr]    <= r_req_pc;
               r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
               r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
         end
      end
   end

   // Head fields read as zero while the buffer is empty.
   always_comb begin
      fetch.IMemReq    = w_req;
      fetch.IMemAddr   = r_pc;
      fetch.InstrValid = w_valid;
      fetch.Instr      = 32'h0;
      fetch.Op         = 6'd0;
      fetch.PCOut      = 32'h0;
      fetch.IllegalOp  = 1'b0;
      if (w_valid) begin
         fetch.Instr     = w_head_instr;
         fetch.Op        = w_head_instr[31:26];
         fetch.PCOut     = w_head_pc;
         fetch.IllegalOp = ~w_legal;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic clk;
  logic rst_n;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fetch (bus)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .fetch (bus2)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int errors  = 0;

  logic [63:0] exp_q[$];        // {instr, pc} entries the decoder must see, in order
  logic [31:0] m_pc;
  logic        m_inflight;
  logic [31:0] m_inflight_pc;

  logic        prev_req;
  logic [31:0] prev_addr;

  logic        obs_valid, obs_req, obs_illegal, obs2_req;
  logic [31:0] obs_pc, obs_addr, obs2_addr, obs2_pc;
  logic [5:0]  obs_op;

  logic [5:0]  op_tbl [8] = '{6'd20, 6'd25, 6'd26, 6'd39, 6'd40, 6'd41, 6'd42, 6'd7};
  logic [31:0] wrap_tbl [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [2:0] idx;
    idx = addr[4:2];
    return {op_tbl[idx], addr[27:2]};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'd20, 6'd25, 6'd26, 6'd39, 6'd40, 6'd41, 6'd42};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc       = 32'h0;
    m_inflight = 1'b0;
    m_inflight_pc = 32'h0;
    prev_req   = 1'b0;
    prev_addr  = 32'h0;
  endtask

  // ---------------- driver + per-cycle compare ----------------
  // Called at a falling edge; drives inputs, checks outputs, advances model,
  // returns at the next falling edge.
  task automatic do_cycle(input logic rd, input logic [31:0] rpc, input logic rdy);
    logic        exp_valid, exp_pop, exp_req;
    logic [63:0] head;
    int          occ;
    bus.Redirect   = rd;
    bus.RedirectPC = rpc;
    bus.InstrReady = rdy;
    bus.IMemData   = prev_req ? mem_word(prev_addr) : $urandom;
    bus2.Redirect   = 1'b0;
    bus2.RedirectPC = 32'h0;
    bus2.InstrReady = 1'b1;
    bus2.IMemData   = 32'h5000_0000;
    #1;
    exp_valid = (exp_q.size() != 0);
    chk("instr_valid", {31'b0, bus.InstrValid}, {31'b0, exp_valid});
    if (exp_valid) begin
      head = exp_q[0];
      chk("instr", bus.Instr, head[63:32]);
      chk("op", {26'b0, bus.Op}, {26'b0, head[63:58]});
      chk("pc_out", bus.PCOut, head[31:0]);
      chk("illegal_op", {31'b0, bus.IllegalOp}, {31'b0, ~is_legal(head[63:58])});
    end
    exp_pop = exp_valid & rdy;
    occ = exp_q.size() + (m_inflight ? 1 : 0) - (exp_pop ? 1 : 0);
    exp_req = !rd && (occ < 2);
    chk("imem_req", {31'b0, bus.IMemReq}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", bus.IMemAddr, m_pc);

    obs_valid = bus.InstrValid;  obs_pc = bus.PCOut;  obs_op = bus.Op;
    obs_illegal = bus.IllegalOp; obs_req = bus.IMemReq; obs_addr = bus.IMemAddr;
    obs2_req = bus2.IMemReq; obs2_addr = bus2.IMemAddr; obs2_pc = bus2.PCOut;
    prev_req  = bus.IMemReq;
    prev_addr = bus.IMemAddr;

    if (rd) begin
      exp_q.delete();
      m_inflight = 1'b0;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (exp_pop) void'(exp_q.pop_front());
      if (m_inflight) exp_q.push_back({mem_word(m_inflight_pc), m_inflight_pc});
      m_inflight = exp_req;
      if (exp_req) begin
        m_inflight_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] stall_pc;
    logic        found;
    rst_n = 1'b0;
    bus.Redirect = 1'b0; bus.RedirectPC = 32'h0; bus.InstrReady = 1'b0; bus.IMemData = 32'h0;
    bus2.Redirect = 1'b0; bus2.RedirectPC = 32'h0; bus2.InstrReady = 1'b1; bus2.IMemData = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, bus.IMemReq}, 32'd0);
    chk("rst_valid", {31'b0, bus.InstrValid}, 32'd0);
    chk("rst_pc_out", bus.PCOut, 32'd0);
    rst_n = 1'b1;

    // Fill and stream with ready held high.
    for (int k = 0; k < 12; k++) begin
      do_cycle(1'b0, 32'h0, 1'b1);
      chk("stream_addr", obs_addr, 32'(4 * k));
      if (k < 4) chk("wrap_addr", obs2_addr, wrap_tbl[k]);
      if (k < 2) chk("fill_valid", {31'b0, obs_valid}, 32'd0);
      if (k >= 2 && k <= 4) chk("stream_pc", obs_pc, 32'(4 * (k - 2)));
      if (k == 2) chk("wrap_pc", obs2_pc, 32'hFFFF_FFF8);
      if (k == 8) begin
        chk("op42", {26'b0, obs_op}, 32'd42);
        chk("op42_illegal", {31'b0, obs_illegal}, 32'd0);
      end
      if (k == 9) begin
        chk("op7", {26'b0, obs_op}, 32'd7);
        chk("op7_illegal", {31'b0, obs_illegal}, 32'd1);
      end
    end

    // Decoder stall for 5 cycles, then drain.
    stall_pc = 32'h0;
    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b0, 32'h0, 1'b0);
      if (k == 0) stall_pc = obs_pc;
      chk("stall_pc", obs_pc, stall_pc);
      chk("stall_no_req", {31'b0, obs_req}, 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b0, 32'h0, 1'b1);
      chk("drain_pc", obs_pc, stall_pc + 32'(4 * k));
    end

    // Redirect with a request in flight.
    do_cycle(1'b1, 32'h0000_0103, 1'b1);
    do_cycle(1'b0, 32'h0, 1'b1);
    chk("redir_addr", obs_addr, 32'h0000_0100);
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b0, 32'h0, 1'b1);
      if (!found && obs_valid) begin
        found = 1'b1;
        chk("redir_pc", obs_pc, 32'h0000_0100);
      end
    end
    chk("redir_valid_seen", {31'b0, found}, 32'd1);

    // Back-to-back redirects: only the last one counts.
    do_cycle(1'b1, 32'h0000_0200, 1'b1);
    do_cycle(1'b1, 32'h0000_0305, 1'b0);
    do_cycle(1'b0, 32'h0, 1'b1);
    chk("redir2_addr", obs_addr, 32'h0000_0304);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      logic rd;
      rd = ($urandom_range(0, 99) < 5);
      do_cycle(rd, $urandom, ($urandom_range(0, 99) < 70));
    end

    // Asynchronous reset while the buffer is full.
    for (int k = 0; k < 4; k++) do_cycle(1'b0, 32'h0, 1'b0);
    chk("full_before_rst", {31'b0, obs_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, bus.InstrValid}, 32'd0);
    chk("arst_req", {31'b0, bus.IMemReq}, 32'd0);
    chk("arst_instr", bus.Instr, 32'd0);
    chk("arst_pc_out", bus.PCOut, 32'd0);
    chk("arst_illegal", {31'b0, bus.IllegalOp}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      do_cycle(1'b0, 32'h0, 1'b1);
      if (!found && obs_valid) begin
        found = 1'b1;
        chk("post_rst_pc", obs_pc, 32'h0);
      end
    end
    chk("post_rst_valid_seen", {31'b0, found}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
